// File: rtl/register_bank_if.sv
// Register bank bus bundle: external write port, two read ports and the
// register-to-register copy request/status signals.
interface register_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_stall;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              cp_req;
    logic [ADDR_W-1:0] cp_src;
    logic [ADDR_W-1:0] cp_dst;
    logic              cp_busy;
    logic              cp_done;

    // Requester side: drives writes, read addresses and copy requests.
    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_addr_a, rd_addr_b,
        output cp_req, cp_src, cp_dst,
        input  wr_stall, rd_data_a, rd_data_b, cp_busy, cp_done
    );

    // Register bank side.
    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_addr_a, rd_addr_b,
        input  cp_req, cp_src, cp_dst,
        output wr_stall, rd_data_a, rd_data_b, cp_busy, cp_done
    );
endinterface

// File: rtl/register_bank.sv
// Register bank with one write port, two combinational read ports and a
// three-state copy engine (IDLE -> READ -> WRITE) that moves one register
// into another. While the copy engine writes, it owns the write port and
// any external write in that cycle is dropped and flagged with wr_stall.
module register_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    register_bank_if.slave   bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [DATA_W-1:0] temp_r;
    logic              cp_busy_r;
    logic              cp_done_r;
    logic [DATA_W-1:0] regs_r [NUM_REGS];

    logic              copy_wr_s;
    logic              ext_wr_s;

    // Write-port arbitration: the copy engine wins in its WRITE state.
    always_comb begin
        copy_wr_s = (state_r == ST_WRITE);
        ext_wr_s  = bus.wr_en & ~copy_wr_s;
    end

    // Copy FSM; busy/done are registered alongside the state so they
    // are glitch-free and line up exactly with READ/WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            src_r     <= '0;
            dst_r     <= '0;
            temp_r    <= '0;
            cp_busy_r <= 1'b0;
            cp_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.cp_req) begin
                        src_r     <= bus.cp_src;
                        dst_r     <= bus.cp_dst;
                        state_r   <= ST_READ;
                        cp_busy_r <= 1'b1;
                        cp_done_r <= 1'b0;
                    end else begin
                        state_r   <= ST_IDLE;
                        cp_busy_r <= 1'b0;
                        cp_done_r <= 1'b0;
                    end
                end
                ST_READ: begin
                    // Non-blocking capture takes the pre-write value even
                    // if an external write hits src on this same edge.
                    temp_r    <= regs_r[src_r];
                    state_r   <= ST_WRITE;
                    cp_busy_r <= 1'b1;
                    cp_done_r <= 1'b1;
                end
                ST_WRITE: begin
                    // Requests seen here are ignored; the next copy can
                    // only start from IDLE.
                    state_r   <= ST_IDLE;
                    cp_busy_r <= 1'b0;
                    cp_done_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cp_busy_r <= 1'b0;
                    cp_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Register array update: copy write in WRITE, external write otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            if (copy_wr_s) begin
                regs_r[dst_r] <= temp_r;
            end else if (ext_wr_s) begin
                regs_r[bus.wr_addr] <= bus.wr_data;
            end else begin
                regs_r[bus.wr_addr] <= regs_r[bus.wr_addr];
            end
        end
    end

    // Read ports have no write bypass; a write shows up after its edge.
    assign bus.rd_data_a = regs_r[bus.rd_addr_a];
    assign bus.rd_data_b = regs_r[bus.rd_addr_b];
    assign bus.wr_stall  = bus.wr_en & copy_wr_s;
    assign bus.cp_busy   = cp_busy_r;
    assign bus.cp_done   = cp_done_r;
endmodule

// File: tb/tb_register_bank.sv
// Directed testbench for register_bank: reads, writes, copy sequencing,
// write-port stalling, mid-copy reset and back-to-back copies.
module tb_register_bank;
    logic clk;
    logic rst_n;
    int   checks_cnt;
    int   fail_cnt;
    logic [31:0] rd_v;
    logic [7:0]  done_v;

    register_bank_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    register_bank #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, landing 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read a register through port B (settles combinationally).
    task automatic read_reg(input logic [3:0] addr, output logic [31:0] data);
        bus.rd_addr_b = addr;
        #1;
        data = bus.rd_data_b;
    endtask

    task automatic idle_inputs();
        bus.wr_en   = 1'b0;
        bus.wr_addr = 4'd0;
        bus.wr_data = 32'd0;
        bus.cp_req  = 1'b0;
        bus.cp_src  = 4'd0;
        bus.cp_dst  = 4'd0;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        idle_inputs();
        bus.rd_addr_a = 4'd3;
        bus.rd_addr_b = 4'd3;
        rst_n = 1'b0;
        #12;
        check_eq("rst_cp_busy",  {31'd0, bus.cp_busy},  32'd0);
        check_eq("rst_cp_done",  {31'd0, bus.cp_done},  32'd0);
        check_eq("rst_wr_stall", {31'd0, bus.wr_stall}, 32'd0);
        check_eq("rst_rd_a",     bus.rd_data_a,         32'd0);
        check_eq("rst_rd_b",     bus.rd_data_b,         32'd0);
        tick();
        rst_n = 1'b1;

        // Write reg3 on the very first edge after reset release.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd3;
        bus.wr_data = 32'hDEADBEEF;
        #1;
        check_eq("rd_before_edge", bus.rd_data_a,          32'd0);
        check_eq("idle_no_stall",  {31'd0, bus.wr_stall},  32'd0);
        tick();
        bus.wr_en = 1'b0;
        #1;
        check_eq("rd_a_reg3", bus.rd_data_a, 32'hDEADBEEF);
        check_eq("rd_b_reg3", bus.rd_data_b, 32'hDEADBEEF);

        // Copy 2 -> 9.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd2;
        bus.wr_data = 32'h12345678;
        tick();
        bus.wr_en  = 1'b0;
        bus.cp_req = 1'b1;
        bus.cp_src = 4'd2;
        bus.cp_dst = 4'd9;
        tick();
        bus.cp_req = 1'b0;
        #1;
        check_eq("cp_read_busy", {31'd0, bus.cp_busy}, 32'd1);
        check_eq("cp_read_done", {31'd0, bus.cp_done}, 32'd0);
        read_reg(4'd9, rd_v);
        check_eq("cp_dst_not_yet", rd_v, 32'd0);
        tick();
        check_eq("cp_write_busy", {31'd0, bus.cp_busy}, 32'd1);
        check_eq("cp_write_done", {31'd0, bus.cp_done}, 32'd1);
        tick();
        check_eq("cp_idle_busy", {31'd0, bus.cp_busy}, 32'd0);
        check_eq("cp_idle_done", {31'd0, bus.cp_done}, 32'd0);
        read_reg(4'd9, rd_v);
        check_eq("cp_reg9", rd_v, 32'h12345678);
        read_reg(4'd2, rd_v);
        check_eq("cp_reg2_kept", rd_v, 32'h12345678);

        // Copy 2 -> 10 with external writes to reg5 in READ and WRITE.
        bus.cp_req = 1'b1;
        bus.cp_src = 4'd2;
        bus.cp_dst = 4'd10;
        tick();
        bus.cp_req  = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd5;
        bus.wr_data = 32'h0000AAAA;
        #1;
        check_eq("read_no_stall", {31'd0, bus.wr_stall}, 32'd0);
        tick();
        bus.wr_data = 32'h0000BBBB;
        #1;
        check_eq("write_stall", {31'd0, bus.wr_stall}, 32'd1);
        tick();
        bus.wr_en = 1'b0;
        #1;
        check_eq("post_stall_clear", {31'd0, bus.wr_stall}, 32'd0);
        read_reg(4'd5, rd_v);
        check_eq("reg5_read_write_kept", rd_v, 32'h0000AAAA);
        read_reg(4'd10, rd_v);
        check_eq("reg10_copied", rd_v, 32'h12345678);

        // Copy 4 -> 7 while reg4 is overwritten during READ.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd4;
        bus.wr_data = 32'h00000001;
        tick();
        bus.wr_en  = 1'b0;
        bus.cp_req = 1'b1;
        bus.cp_src = 4'd4;
        bus.cp_dst = 4'd7;
        tick();
        bus.cp_req  = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd4;
        bus.wr_data = 32'h00000002;
        tick();
        bus.wr_en = 1'b0;
        tick();
        read_reg(4'd7, rd_v);
        check_eq("reg7_prewrite", rd_v, 32'h00000001);
        read_reg(4'd4, rd_v);
        check_eq("reg4_ext_write", rd_v, 32'h00000002);

        // Reset pulsed in the WRITE phase of copy 2 -> 11.
        bus.cp_req = 1'b1;
        bus.cp_src = 4'd2;
        bus.cp_dst = 4'd11;
        tick();
        bus.cp_req = 1'b0;
        tick();
        check_eq("abort_in_write", {31'd0, bus.cp_done}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_done_clr", {31'd0, bus.cp_done}, 32'd0);
        check_eq("abort_busy_clr", {31'd0, bus.cp_busy}, 32'd0);
        read_reg(4'd2, rd_v);
        check_eq("abort_reg2_clr", rd_v, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("abort_no_done", {31'd0, bus.cp_done}, 32'd0);
        check_eq("abort_idle",    {31'd0, bus.cp_busy}, 32'd0);
        read_reg(4'd11, rd_v);
        check_eq("abort_reg11", rd_v, 32'd0);
        read_reg(4'd3, rd_v);
        check_eq("abort_reg3", rd_v, 32'd0);

        // cp_req held for 6 edges, src == dst == 1.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd1;
        bus.wr_data = 32'hCAFEF00D;
        tick();
        bus.wr_en  = 1'b0;
        bus.cp_req = 1'b1;
        bus.cp_src = 4'd1;
        bus.cp_dst = 4'd1;
        done_v = 8'd0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 5) begin
                bus.cp_req = 1'b0;
            end
            done_v[k] = bus.cp_done;
        end
        check_eq("b2b_done_pattern", {24'd0, done_v}, 32'h00000012);
        read_reg(4'd1, rd_v);
        check_eq("b2b_reg1_kept", rd_v, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
